ps2_frame_rx: RTL and testbench

Front-end PS/2 deserializer that sits between the keyboard pins and the key-mapping stage that drives the player control vectors. It synchronizes and glitch-filters the keyboard clock, and frames 11-bit PS/2 packets with odd-parity and stop-bit checking. It folds the E0 (extended) and F0 (break) prefixes into a single key event, so the mapping stage sees one clean, qualified event per key press or release. It also provides a last-byte output for the debug LEDs.

---
 rtl/ps2_frame_rx.sv | 175 +++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the pins, frames 11-bit packets,
// and folds E0/F0 prefixes into one qualified key event per press or release.
module ps2_frame_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       keyb_clk,
  input  logic       kdata,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic [7:0] raw_byte,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;
  logic                   kclk_f;
  logic                   fall;
  logic [FW-1:0]          flt_cnt;
  state_t                 state;
  state_t                 state_nx;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TW-1:0]          to_cnt;
  logic                   timeout;
  logic                   frame_ok;
  logic                   frame_bad;
  logic                   ext_pend;
  logic                   brk_pend;

  // Idle PS/2 lines are high, so the synchronizers reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], keyb_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], kdata};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // kclk_f flips on the FILTER_LEN-th consecutive differing sample; fall marks a 1->0 flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_f  <= 1'b1;
      flt_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == kclk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        kclk_f  <= clk_s;
        flt_cnt <= '0;
        fall    <= kclk_f;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_s) state_nx = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Timeout wins over a coincident stop-bit edge so a frame never yields both pulses.
  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = timeout;
    if (!timeout && fall && (state == STOP)) begin
      if (data_s && (^{shreg, par_bit})) frame_ok  = 1'b1;
      else                               frame_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if ((state == IDLE) || fall) to_cnt <= '0;
      else if (!timeout)           to_cnt <= to_cnt + TW'(1);
      if (timeout) begin
        shreg <= '0;
      end else if (fall) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par_bit <= data_s;
          default: ;
        endcase
      end
    end
  end

  // Prefix bytes only arm a pending flag; any other accepted byte closes the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      raw_byte  <= '0;
      frame_err <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= frame_bad;
      if (frame_bad) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (frame_ok) begin
        raw_byte <= shreg;
        if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          key_code  <= shreg;
          key_ext   <= ext_pend;
          key_break <= brk_pend;
          key_valid <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: directed frame table, multi-cycle corner sequences,
// and random frames checked against a prefix-folding reference model.
module tb_ps2_frame_rx;

  localparam int SYNC = 2;
  localparam int FILT = 8;
  localparam int TO   = 400;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       keyb_clk = 1'b1;
  logic       kdata = 1'b1;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic [7:0] raw_byte;
  logic       frame_err;

  ps2_frame_rx #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keyb_clk  (keyb_clk),
    .kdata     (kdata),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .key_valid (key_valid),
    .raw_byte  (raw_byte),
    .frame_err (frame_err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records pulses on the falling edge, away from the active edge
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  int valid_total = 0;
  int err_total = 0;
  int overlap = 0;
  int last_valid_cyc = 0;
  int last_err_cyc = 0;
  always @(negedge clk) begin
    if (key_valid) begin
      obs_q.push_back({key_ext, key_break, key_code});
      valid_total++;
      last_valid_cyc = cyc;
    end
    if (frame_err) begin
      err_total++;
      last_err_cyc = cyc;
    end
    if (key_valid && frame_err) overlap++;
  end

  int checks = 0;
  int errors = 0;
  int last_fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one PS/2 frame (or its first nbits bits) with half-period h cycles.
  task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop_bad,
                            input int nbits, input logic glitch, input int h);
    logic [10:0] fr;
    fr = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kdata = fr[i];
      if (glitch) begin
        repeat (h / 2) @(negedge clk);
        keyb_clk = 1'b0;
        repeat (3) @(negedge clk);
        keyb_clk = 1'b1;
        repeat (h - h / 2 - 3) @(negedge clk);
      end else begin
        repeat (h) @(negedge clk);
      end
      keyb_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (h) @(negedge clk);
      keyb_clk = 1'b1;
    end
    kdata = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " key_code"}, key_code, 8'h00);
    check({tag, " key_ext"}, key_ext, 1'b0);
    check({tag, " key_break"}, key_break, 1'b0);
    check({tag, " key_valid"}, key_valid, 1'b0);
    check({tag, " raw_byte"}, raw_byte, 8'h00);
    check({tag, " frame_err"}, frame_err, 1'b0);
    check({tag, " state"}, 32'(dut.state), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_bad;
    logic       stop_bad;
    logic       exp_valid;
    logic [7:0] exp_code;
    logic       exp_ext;
    logic       exp_brk;
    logic       exp_err;
    logic [7:0] exp_raw;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int v0;
    int e0;
    int d;
    int h;
    logic [7:0] b;
    logic bad;
    logic m_ext;
    logic m_brk;
    logic [7:0] m_raw;
    int m_err;
    int obs_start;
    logic [9:0] got;

    vecs[0]  = '{8'h1D, N, N, Y, 8'h1D, N, N, N, 8'h1D};
    vecs[1]  = '{8'hE0, N, N, N, 8'h00, N, N, N, 8'hE0};
    vecs[2]  = '{8'hF0, N, N, N, 8'h00, N, N, N, 8'hF0};
    vecs[3]  = '{8'h75, N, N, Y, 8'h75, Y, Y, N, 8'h75};
    vecs[4]  = '{8'h29, Y, N, N, 8'h00, N, N, Y, 8'h75};
    vecs[5]  = '{8'hF0, N, N, N, 8'h00, N, N, N, 8'hF0};
    vecs[6]  = '{8'h29, N, N, Y, 8'h29, N, Y, N, 8'h29};
    vecs[7]  = '{8'hE0, N, N, N, 8'h00, N, N, N, 8'hE0};
    vecs[8]  = '{8'h6B, N, Y, N, 8'h00, N, N, Y, 8'hE0};
    vecs[9]  = '{8'h6B, N, N, Y, 8'h6B, N, N, N, 8'h6B};
    vecs[10] = '{8'hF0, N, N, N, 8'h00, N, N, N, 8'hF0};
    vecs[11] = '{8'hF0, N, N, N, 8'h00, N, N, N, 8'hF0};
    vecs[12] = '{8'h1D, N, N, Y, 8'h1D, N, Y, N, 8'h1D};
    vecs[13] = '{8'hE0, N, N, N, 8'h00, N, N, N, 8'hE0};
    vecs[14] = '{8'h14, Y, N, N, 8'h00, N, N, Y, 8'hE0};
    vecs[15] = '{8'hF0, N, N, N, 8'h00, N, N, N, 8'hF0};
    vecs[16] = '{8'h14, N, N, Y, 8'h14, N, Y, N, 8'h14};
    vecs[17] = '{8'h00, N, N, Y, 8'h00, N, N, N, 8'h00};
    vecs[18] = '{8'hFF, N, N, Y, 8'hFF, N, N, N, 8'hFF};
    vecs[19] = '{8'hE0, N, N, N, 8'h00, N, N, N, 8'hE0};
    vecs[20] = '{8'h1F, N, N, Y, 8'h1F, Y, N, N, 8'h1F};

    // Reset values, both during and right after reset
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("after_reset");

    // Directed frame table
    foreach (vecs[i]) begin
      v0 = valid_total;
      e0 = err_total;
      send_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop_bad, 11, 1'b0, 30);
      check($sformatf("v%0d valid_cnt", i), valid_total - v0, 32'(vecs[i].exp_valid));
      check($sformatf("v%0d err_cnt", i), err_total - e0, 32'(vecs[i].exp_err));
      check($sformatf("v%0d raw_byte", i), raw_byte, vecs[i].exp_raw);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d key_code", i), key_code, vecs[i].exp_code);
        check($sformatf("v%0d key_ext", i), key_ext, vecs[i].exp_ext);
        check($sformatf("v%0d key_break", i), key_break, vecs[i].exp_brk);
      end
      if (i == 0) check("pin_to_valid_latency", last_valid_cyc - last_fall_cyc, SYNC + FILT + 1);
    end

    // A falling edge with data high in IDLE is not a start bit
    v0 = valid_total;
    e0 = err_total;
    kdata = 1'b1;
    repeat (30) @(negedge clk);
    keyb_clk = 1'b0;
    repeat (30) @(negedge clk);
    keyb_clk = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_high_err", err_total - e0, 0);
    check("idle_high_valid", valid_total - v0, 0);
    check("idle_high_state", 32'(dut.state), 32'd0);

    // Glitch rejection: 3-cycle low pulses inside every high phase
    v0 = valid_total;
    e0 = err_total;
    send_frame(8'h6C, N, N, 11, 1'b1, 30);
    check("glitch_valid", valid_total - v0, 1);
    check("glitch_err", err_total - e0, 0);
    check("glitch_code", key_code, 8'h6C);
    check("glitch_raw", raw_byte, 8'h6C);

    // Timeout after 4 data bits; the armed E0 must be dropped
    send_frame(8'hE0, N, N, 11, 1'b0, 30);
    v0 = valid_total;
    e0 = err_total;
    send_frame(8'h55, N, N, 5, 1'b0, 30);
    repeat (TO + 40) @(negedge clk);
    check("timeout_err_cnt", err_total - e0, 1);
    check("timeout_valid_cnt", valid_total - v0, 0);
    d = last_err_cyc - last_fall_cyc;
    checks++;
    if (d < TO + SYNC + FILT + 1 || d > TO + SYNC + FILT + 3) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, expected about %0d", d, TO + SYNC + FILT + 2);
    end
    check("timeout_state", 32'(dut.state), 32'd0);
    check("timeout_raw_hold", raw_byte, 8'hE0);
    send_frame(8'h74, N, N, 11, 1'b0, 30);
    check("after_to_valid", valid_total - v0, 1);
    check("after_to_code", key_code, 8'h74);
    check("after_to_ext", key_ext, 1'b0);
    check("after_to_err", err_total - e0, 1);

    // Reset in the middle of a frame
    v0 = valid_total;
    e0 = err_total;
    send_frame(8'h33, N, N, 4, 1'b0, 30);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, N, N, 11, 1'b0, 30);
    check("post_reset_valid", valid_total - v0, 1);
    check("post_reset_err", err_total - e0, 0);
    check("post_reset_code", key_code, 8'h5A);
    check("post_reset_raw", raw_byte, 8'h5A);

    // Random frames against the reference model
    exp_q.delete();
    obs_start = obs_q.size();
    e0 = err_total;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_raw = raw_byte;
    m_err = 0;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 7) == 0);
      h = $urandom_range(20, 40);
      if (bad) begin
        m_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else begin
        m_raw = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
          exp_q.push_back({m_ext, m_brk, b});
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      end
      if (bad && $urandom_range(0, 1) == 0) send_frame(b, 1'b1, 1'b0, 11, $urandom_range(0, 3) == 0, h);
      else if (bad) send_frame(b, 1'b0, 1'b1, 11, $urandom_range(0, 3) == 0, h);
      else send_frame(b, 1'b0, 1'b0, 11, $urandom_range(0, 3) == 0, h);
    end
    check("rand_event_cnt", obs_q.size() - obs_start, exp_q.size());
    check("rand_err_cnt", err_total - e0, m_err);
    check("rand_raw", raw_byte, m_raw);
    foreach (exp_q[i]) begin
      if (obs_start + i < obs_q.size()) begin
        got = obs_q[obs_start + i];
        check($sformatf("rand_event%0d", i), got, exp_q[i]);
      end
    end

    check("valid_err_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
